// File: rtl/button_pkg.sv
// Shared encodings for the toggle-button stimulus generator and the toggle FSM bench.
package button_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRESS = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic MODE_COUNT = 1'b0;
  localparam logic MODE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_PRESS = ST_PRESS,
    S_GAP   = ST_GAP
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_press_gen_cycle_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module cycle_timer
  import button_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/button_press_gen.sv
// Turns press commands into a clean registered press/release waveform and tracks
// the predicted output of the downstream toggle FSM.
//
// state | meaning
// IDLE  | waiting for a command; cmd_ready high
// PRESS | button held high for HOLD_CYCLES
// GAP   | button held low for GAP_CYCLES, then next press or back to IDLE
module button_press_gen
  import button_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic [CNT_W-1:0] cmd_presses,
  input  logic             cmd_level,
  input  logic             abort,
  output logic             button,
  output logic             model_state,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam int TMR_W = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]   req, rem;
  logic               pend, pend_nxt;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_expired;
  logic               flip;
  logic               done_nxt, aborted_nxt;

  cycle_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pend_nxt    = pend;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    flip        = 1'b0;
    done_nxt    = 1'b0;
    aborted_nxt = 1'b0;
    req         = '0;
    rem         = '0;
    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          pend_nxt = 1'b0;
          req = (cmd_mode == MODE_LEVEL) ? CNT_W'(cmd_level ^ model_state) : cmd_presses;
          cnt_nxt = req;
          if (req == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = S_PRESS;
            tmr_load  = 1'b1;
            tmr_val   = HOLD_LOAD;
            flip      = 1'b1;
          end
        end
      end
      S_PRESS: begin
        if (abort) pend_nxt = 1'b1;
        if (tmr_expired) begin
          state_nxt = S_GAP;
          tmr_load  = 1'b1;
          tmr_val   = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (abort) pend_nxt = 1'b1;
        if (tmr_expired) begin
          rem     = (cnt == '0) ? '0 : cnt - CNT_W'(1);
          cnt_nxt = rem;
          if (rem == '0 || pend_nxt) begin
            state_nxt   = S_IDLE;
            done_nxt    = 1'b1;
            // An abort landing during the final press cut nothing short.
            aborted_nxt = pend_nxt && (rem != '0);
            pend_nxt    = 1'b0;
          end else begin
            state_nxt = S_PRESS;
            tmr_load  = 1'b1;
            tmr_val   = HOLD_LOAD;
            flip      = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      pend        <= 1'b0;
      button      <= 1'b0;
      model_state <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      cmd_ready   <= 1'b1;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pend        <= pend_nxt;
      button      <= (state_nxt == S_PRESS);
      model_state <= model_state ^ flip;
      busy        <= (state_nxt != S_IDLE);
      done        <= done_nxt;
      aborted     <= aborted_nxt;
      cmd_ready   <= (state_nxt == S_IDLE);
    end
  end

endmodule

// File: tb/tb_button_press_gen.sv
// Bench for button_press_gen: directed scenarios plus randomized commands against a
// waveform model, with a downstream toggle FSM checked against model_state.
module tb_button_press_gen;

  localparam int H   = 2;
  localparam int G   = 2;
  localparam int CW  = 4;
  localparam int PER = H + G;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_mode = 1'b0;
  logic [CW-1:0] cmd_presses = '0;
  logic          cmd_level = 1'b0;
  logic          abort = 1'b0;
  logic          button, model_state, busy, done, aborted;

  int n_cmp = 0;
  int n_err = 0;
  bit ref_level = 1'b0;
  bit mon_en = 1'b0;

  button_press_gen #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_mode    (cmd_mode),
    .cmd_presses (cmd_presses),
    .cmd_level   (cmd_level),
    .abort       (abort),
    .button      (button),
    .model_state (model_state),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted)
  );

  always #5 clk = ~clk;

  // downstream toggle FSM: flips on each sampled rising edge of button
  logic tog_prev, toggle_out, ms_d1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tog_prev   <= 1'b0;
      toggle_out <= 1'b0;
      ms_d1      <= 1'b0;
    end else begin
      tog_prev <= button;
      if (button && !tog_prev) toggle_out <= ~toggle_out;
      ms_d1 <= model_state;
    end
  end

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      n_cmp++;
      if (toggle_out !== ms_d1) begin
        n_err++;
        $display("FAIL toggle_track t=%0t: toggle %b model_state_d1 %b", $time, toggle_out, ms_d1);
      end
    end
  end

  // Called at a negedge in a cycle where the DUT is ready; returns at the negedge of the done cycle.
  task automatic run_cmd(input bit mode, input int presses, input bit level,
                         input int abort_j, input bit abort_acc, input string tag);
    int n, k, len;
    bit exp_ab, exp_btn;
    n = mode ? int'(level != ref_level) : presses;
    k = n;
    if (abort_j > 0 && n > 0 && abort_j <= n * PER) k = (abort_j - 1) / PER + 1;
    len = k * PER;
    exp_ab = (k < n);
    cmd_valid = 1'b1; cmd_mode = mode; cmd_presses = CW'(presses);
    cmd_level = level; abort = abort_acc;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL %s ready_at_accept: got %b want 1", tag, cmd_ready);
    end
    @(posedge clk); #1;
    abort = 1'b0;
    cmd_presses = CW'($urandom);
    cmd_level = 1'($urandom);
    cmd_mode = 1'($urandom);
    for (int j = 1; j <= len; j++) begin
      abort = (j == abort_j);
      cmd_valid = 1'($urandom);
      @(negedge clk);
      exp_btn = ((j - 1) % PER) < H;
      n_cmp += 4;
      if (button !== exp_btn) begin
        n_err++; $display("FAIL %s button cyc %0d: got %b want %b", tag, j, button, exp_btn);
      end
      if (busy !== 1'b1) begin
        n_err++; $display("FAIL %s busy cyc %0d: got %b want 1", tag, j, busy);
      end
      if (done !== 1'b0) begin
        n_err++; $display("FAIL %s early_done cyc %0d: got %b want 0", tag, j, done);
      end
      if (cmd_ready !== 1'b0) begin
        n_err++; $display("FAIL %s ready_busy cyc %0d: got %b want 0", tag, j, cmd_ready);
      end
      @(posedge clk); #1;
    end
    abort = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    ref_level = ref_level ^ k[0];
    n_cmp += 6;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL %s done at E+%0d: got %b want 1", tag, len + 1, done);
    end
    if (aborted !== exp_ab) begin
      n_err++; $display("FAIL %s aborted: got %b want %b", tag, aborted, exp_ab);
    end
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL %s busy_at_done: got %b want 0", tag, busy);
    end
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL %s ready_at_done: got %b want 1", tag, cmd_ready);
    end
    if (button !== 1'b0) begin
      n_err++; $display("FAIL %s button_at_done: got %b want 0", tag, button);
    end
    if (model_state !== ref_level) begin
      n_err++; $display("FAIL %s model_state: got %b want %b", tag, model_state, ref_level);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp += 6;
    if (button !== 1'b0)      begin n_err++; $display("FAIL reset button: got %b want 0", button); end
    if (model_state !== 1'b0) begin n_err++; $display("FAIL reset model_state: got %b want 0", model_state); end
    if (busy !== 1'b0)        begin n_err++; $display("FAIL reset busy: got %b want 0", busy); end
    if (done !== 1'b0)        begin n_err++; $display("FAIL reset done: got %b want 0", done); end
    if (aborted !== 1'b0)     begin n_err++; $display("FAIL reset aborted: got %b want 0", aborted); end
    if (cmd_ready !== 1'b1)   begin n_err++; $display("FAIL reset cmd_ready: got %b want 1", cmd_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    ref_level = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_count_three();
    run_cmd(1'b0, 3, 1'b0, 0, 1'b0, "count3");
    n_cmp++;
    if (toggle_out !== 1'b1) begin
      n_err++; $display("FAIL count3 toggle_out: got %b want 1", toggle_out);
    end
    @(negedge clk);
  endtask

  task automatic test_level_mode();
    run_cmd(1'b1, 0, 1'b0, 0, 1'b0, "level0");
    @(negedge clk);
    run_cmd(1'b1, 0, 1'b1, 0, 1'b0, "level1");
    @(negedge clk);
    run_cmd(1'b1, 0, 1'b1, 0, 1'b0, "level1_again");
    @(negedge clk);
  endtask

  task automatic test_zero_count();
    run_cmd(1'b0, 0, 1'b0, 0, 1'b0, "zero");
    @(negedge clk);
    run_cmd(1'b0, 2, 1'b0, 0, 1'b1, "abort_at_accept");
    @(negedge clk);
  endtask

  task automatic test_abort();
    run_cmd(1'b1, 0, 1'b0, 0, 1'b0, "abort_prep");
    @(negedge clk);
    run_cmd(1'b0, 5, 1'b0, 6, 1'b0, "abort_press2");
    @(negedge clk);
    run_cmd(1'b0, 4, 1'b0, 3, 1'b0, "abort_gap1");
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_presses = CW'(2); abort = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    #1;
    n_cmp++;
    if (button !== 1'b1) begin n_err++; $display("FAIL arst pre_button: got %b want 1", button); end
    rst_n = 1'b0;
    #1;
    n_cmp += 6;
    if (button !== 1'b0)      begin n_err++; $display("FAIL arst button: got %b want 0", button); end
    if (model_state !== 1'b0) begin n_err++; $display("FAIL arst model_state: got %b want 0", model_state); end
    if (busy !== 1'b0)        begin n_err++; $display("FAIL arst busy: got %b want 0", busy); end
    if (done !== 1'b0)        begin n_err++; $display("FAIL arst done: got %b want 0", done); end
    if (aborted !== 1'b0)     begin n_err++; $display("FAIL arst aborted: got %b want 0", aborted); end
    if (cmd_ready !== 1'b1)   begin n_err++; $display("FAIL arst cmd_ready: got %b want 1", cmd_ready); end
    ref_level = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL arst ready_after: got %b want 1", cmd_ready); end
  endtask

  task automatic test_back_to_back();
    run_cmd(1'b0, 2, 1'b0, 0, 1'b0, "b2b_a");
    run_cmd(1'b0, 1, 1'b0, 0, 1'b0, "b2b_b");
    run_cmd(1'b1, 0, ~ref_level, 0, 1'b0, "b2b_c");
    run_cmd(1'b0, 0, 1'b0, 0, 1'b0, "b2b_d");
    run_cmd(1'b0, 3, 1'b0, 0, 1'b0, "b2b_e");
    @(negedge clk);
  endtask

  task automatic test_random();
    int gap;
    for (int i = 0; i < 30; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        abort = 1'($urandom);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL rand idle_done %0d: got %b want 0", i, done); end
      end
      abort = 1'b0;
      run_cmd(1'($urandom), $urandom_range(0, 6), 1'($urandom),
              ($urandom_range(0, 2) == 0) ? $urandom_range(1, 24) : 0,
              1'($urandom), $sformatf("rand%0d", i));
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_count_three();
    test_level_mode();
    test_zero_count();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
